// File: rtl/blft_param.sv
// Raster-order window filter: bypass, box mean or range-gated mean over a clamped
// (2R+1)x(2R+1) window, fetched pixel by pixel from external memory.
module blft_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned W_LOG2 = 8,
  parameter int unsigned H_LOG2 = 8,
  parameter int unsigned RADIUS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        thresh,
  input  logic                     in_valid,
  output logic [H_LOG2+W_LOG2-1:0] in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [H_LOG2+W_LOG2-1:0] out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     finish
);

  localparam int unsigned AW = H_LOG2 + W_LOG2;
  localparam int unsigned SW = DATA_W + 8;
  localparam int unsigned NW = DATA_W + 9;
  localparam int ROW_MAX = (1 << H_LOG2) - 1;
  localparam int COL_MAX = (1 << W_LOG2) - 1;
  localparam logic signed [4:0] RPOS = 5'(RADIUS);
  localparam logic signed [4:0] RNEG = -RPOS;

  typedef enum logic [2:0] {StIdle, StCenter, StWin, StDiv, StOut, StDone} state_e;

  state_e              state_q;
  logic [H_LOG2-1:0]   row_q;
  logic [W_LOG2-1:0]   col_q;
  logic signed [4:0]   dy_q, dx_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   thresh_q, center_q;
  logic [SW-1:0]       sum_q;
  logic [7:0]          cnt_q, rem_q, div_cnt_q;
  logic [DATA_W-1:0]   quo_q;
  logic                sat_q;
  logic                out_valid_q;
  logic [AW-1:0]       out_addr_q;
  logic [DATA_W-1:0]   out_data_q;

  int                  ry, cx;
  logic [H_LOG2-1:0]   row_cl;
  logic [W_LOG2-1:0]   col_cl;
  logic [DATA_W-1:0]   diff;
  logic                incl, last_win;
  logic [SW-1:0]       sum_nxt;
  logic [7:0]          cnt_nxt;
  logic [NW-1:0]       dvd;
  logic [8:0]          dvd_hi;
  logic [8:0]          shifted;
  logic                ge;
  logic [7:0]          rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;

  // Edge clamping of the window tap address.
  always_comb begin
    ry = int'(row_q) + int'(dy_q);
    cx = int'(col_q) + int'(dx_q);
    if (ry < 0)            row_cl = '0;
    else if (ry > ROW_MAX) row_cl = H_LOG2'(ROW_MAX);
    else                   row_cl = H_LOG2'(ry);
    if (cx < 0)            col_cl = '0;
    else if (cx > COL_MAX) col_cl = W_LOG2'(COL_MAX);
    else                   col_cl = W_LOG2'(cx);
  end

  always_comb begin
    diff     = (in_data >= center_q) ? in_data - center_q : center_q - in_data;
    incl     = (mode_q == 2'b01) || (diff <= thresh_q);
    sum_nxt  = incl ? sum_q + SW'(in_data) : sum_q;
    cnt_nxt  = incl ? cnt_q + 8'd1 : cnt_q;
    last_win = (dx_q == RPOS) && (dy_q == RPOS);
    // Round half up by biasing the dividend with cnt/2.
    dvd      = NW'(sum_nxt) + NW'(cnt_nxt >> 1);
    dvd_hi   = dvd[NW-1:DATA_W];
    // The quotient fits DATA_W bits, so the high dividend part seeds the remainder.
    shifted  = {rem_q, quo_q[DATA_W-1]};
    ge       = shifted >= {1'b0, cnt_q};
    rem_nxt  = ge ? 8'(shifted - {1'b0, cnt_q}) : shifted[7:0];
    quo_nxt  = {quo_q[DATA_W-2:0], ge};
  end

  always_comb begin
    in_addr = '0;
    case (state_q)
      StCenter, StDiv, StOut: in_addr = {row_q, col_q};
      StWin:                  in_addr = {row_cl, col_cl};
      default:                in_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      dy_q        <= '0;
      dx_q        <= '0;
      mode_q      <= '0;
      thresh_q    <= '0;
      center_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_cnt_q   <= '0;
      quo_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q  <= StCenter;
            row_q    <= '0;
            col_q    <= '0;
            mode_q   <= mode;
            thresh_q <= thresh;
          end
        end
        StCenter: begin
          if (in_valid) begin
            center_q <= in_data;
            if (mode_q == 2'b00) begin
              state_q     <= StOut;
              out_valid_q <= 1'b1;
              out_addr_q  <= {row_q, col_q};
              out_data_q  <= in_data;
            end else begin
              state_q <= StWin;
              sum_q   <= '0;
              cnt_q   <= '0;
              dy_q    <= RNEG;
              dx_q    <= RNEG;
            end
          end
        end
        StWin: begin
          if (in_valid) begin
            sum_q <= sum_nxt;
            cnt_q <= cnt_nxt;
            if (dx_q == RPOS) begin
              dx_q <= RNEG;
              dy_q <= dy_q + 5'sd1;
            end else begin
              dx_q <= dx_q + 5'sd1;
            end
            if (last_win) begin
              state_q   <= StDiv;
              div_cnt_q <= '0;
              sat_q     <= dvd_hi >= {1'b0, cnt_nxt};
              rem_q     <= dvd_hi[7:0];
              quo_q     <= dvd[DATA_W-1:0];
            end
          end
        end
        StDiv: begin
          rem_q     <= rem_nxt;
          quo_q     <= quo_nxt;
          div_cnt_q <= div_cnt_q + 8'd1;
          if (div_cnt_q == 8'(DATA_W - 1)) begin
            state_q     <= StOut;
            out_valid_q <= 1'b1;
            out_addr_q  <= {row_q, col_q};
            out_data_q  <= sat_q ? '1 : quo_nxt;
          end
        end
        StOut: begin
          if (col_q == W_LOG2'(COL_MAX)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
            state_q <= (row_q == H_LOG2'(ROW_MAX)) ? StDone : StCenter;
          end else begin
            col_q   <= col_q + 1'b1;
            state_q <= StCenter;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign finish    = (state_q == StDone);

endmodule

// File: tb/tb_blft_param.sv
// Bench for blft_param on a 4x4 image with R=1: scenario table plus reset and
// start-while-busy sequences, checked against a window-average reference model.
module tb_blft_param;

  localparam int NPIX = 16;
  localparam int SIDE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] thresh = 8'd0;
  logic       in_valid = 1'b1;
  logic [3:0] in_addr;
  logic [7:0] in_data;
  logic       out_valid;
  logic [3:0] out_addr;
  logic [7:0] out_data;
  logic       busy;
  logic       finish;

  logic [7:0] img [NPIX];
  bit         stall_en = 1'b0;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         qa[$], qd[$], qt[$];

  blft_param #(.DATA_W(8), .W_LOG2(2), .H_LOG2(2), .RADIUS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .thresh(thresh),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .finish(finish)
  );

  assign in_data = in_valid ? img[in_addr] : 8'hA5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > SIDE - 1) ? SIDE - 1 : v);
  endfunction

  // Window average straight from the filter definition.
  function automatic int ref_pix(input int m, input int thr, input int r, input int c);
    int ctr, px, sum, cnt, q;
    ctr = int'(img[r * SIDE + c]);
    if (m == 0) return ctr;
    sum = 0;
    cnt = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        px = int'(img[clampi(r + dy) * SIDE + clampi(c + dx)]);
        if (m == 1 || (px > ctr ? px - ctr : ctr - px) <= thr) begin
          sum += px;
          cnt++;
        end
      end
    q = (sum + cnt / 2) / cnt;
    return (q > 255) ? 255 : q;
  endfunction

  // Output capture, in_valid generation and address-hold check during stalls.
  initial begin
    bit piv, pbusy, pov;
    logic [3:0] paddr;
    piv = 1'b1; pbusy = 1'b0; pov = 1'b0; paddr = '0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        qa.push_back(int'(out_addr));
        qd.push_back(int'(out_data));
        qt.push_back(cyc);
      end
      if (!piv && pbusy && !pov && busy && !rst) chk("addr_hold", int'(in_addr), int'(paddr));
      in_valid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      piv = in_valid; pbusy = busy; pov = out_valid; paddr = in_addr;
    end
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] thr;
    int         kind;   // 0 ramp 40r+10c, 1 constant 200, 2 random
    bit         stall;
    bit         poke;   // pulse start with other settings mid-frame
    int         exp0;   // expected first pixel, -1 when random
  } scn_t;

  scn_t tbl [6];

  task automatic fill(input int kind);
    for (int i = 0; i < NPIX; i++)
      img[i] = (kind == 0) ? 8'(40 * (i / SIDE) + 10 * (i % SIDE)) :
               (kind == 1) ? 8'd200 : 8'($urandom_range(0, 255));
  endtask

  task automatic run_scn(input scn_t s);
    int t0, gap;
    bit poked;
    poked = 1'b0;
    fill(s.kind);
    stall_en = s.stall;
    qa.delete(); qd.delete(); qt.delete();
    @(negedge clk);
    mode = s.mode; thresh = s.thr; start = 1'b1; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("finish_drop", int'(finish), 0);
    chk("busy_on", int'(busy), 1);
    for (int k = 0; k < 3000 && !finish; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (s.poke && !poked && qa.size() >= 3) begin
        start = 1'b1; mode = 2'b00; thresh = 8'd255; poked = 1'b1;
      end
    end
    stall_en = 1'b0;
    chk("done_seen", int'(finish), 1);
    chk("busy_off", int'(busy), 0);
    chk("pulses", qa.size(), NPIX);
    for (int k = 0; k < qa.size() && k < NPIX; k++) begin
      chk("addr", qa[k], k);
      chk("data", qd[k], ref_pix(int'(s.mode), int'(s.thr), k / SIDE, k % SIDE));
    end
    if (s.exp0 >= 0 && qd.size() > 0) chk("first_data", qd[0], s.exp0);
    if (!s.stall && qt.size() == NPIX) begin
      gap = (s.mode == 2'b00) ? 2 : 19;
      chk("latency", qt[0] - t0, gap);
      for (int k = 1; k < NPIX; k++) chk("spacing", qt[k] - qt[k - 1], gap);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_addr"}, int'(out_addr), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_finish"}, int'(finish), 0);
    chk({tag, "_in_addr"}, int'(in_addr), 0);
  endtask

  initial begin
    // (0,0) box: sum 150 over 9 -> 17; gated thr 15: sum 20 over 6 -> 3.
    tbl[0] = '{mode: 2'b01, thr: 8'd0,  kind: 0, stall: 1'b0, poke: 1'b0, exp0: 17};
    tbl[1] = '{mode: 2'b10, thr: 8'd15, kind: 0, stall: 1'b0, poke: 1'b1, exp0: 3};
    tbl[2] = '{mode: 2'b00, thr: 8'd0,  kind: 0, stall: 1'b0, poke: 1'b0, exp0: 0};
    tbl[3] = '{mode: 2'b01, thr: 8'd0,  kind: 1, stall: 1'b0, poke: 1'b0, exp0: 200};
    tbl[4] = '{mode: 2'b01, thr: 8'd0,  kind: 0, stall: 1'b1, poke: 1'b0, exp0: 17};
    tbl[5] = '{mode: 2'b11, thr: 8'($urandom_range(10, 80)), kind: 2, stall: 1'b1,
               poke: 1'b0, exp0: -1};
    fill(0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_scn(tbl[i]);

    // Reset in the window scan of pixel 5, then a clean restart.
    fill(0);
    stall_en = 1'b0;
    qa.delete(); qd.delete(); qt.delete();
    @(negedge clk);
    mode = 2'b01; thresh = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400 && qa.size() < 5; k++) @(negedge clk);
    chk("reach_pixel5", qa.size(), 5);
    @(negedge clk);
    @(negedge clk);
    chk("in_win", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("no_pulse_after_reset", qa.size(), 5);
    chk("idle_after_reset", int'(busy), 0);
    run_scn(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
